timer_counter: RTL and testbench

//  Memory-mapped down-counting timer on the CPU system bus; the interrupt source whose
//  irq output drives one bit of CP0's 6-bit HWInt vector. CPU programs PRESET/CTRL via
//  sw, reads COUNT via lw. Count expiry raises irq for CP0 to take as an interrupt (ExcCode 0).

---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_counter.sv | 121 ++++++++++++
 tb/tb_timer_counter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// FSM states, register offsets, CTRL bit positions and MODE encodings.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Bus-mapped down-counting timer; expiry raises a masked interrupt request
// for one bit of CP0's hardware interrupt vector.
module timer_counter
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   state_t      state, state_next;
   logic [3:0]  ctrl, ctrl_next;
   logic [31:0] preset, preset_next;
   logic [31:0] count, count_next;
   logic        irq_flag, irq_flag_next;

   logic        sel;
   logic [1:0]  offset;
   logic        wr_ctrl, wr_preset;
   logic        en, auto_reload;
   logic        set_flag, hw_clear_en, pulse_end;
   logic        unused_addr_bits;

   assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
   assign offset      = addr[3:2];
   assign wr_ctrl     = we && sel && (offset == OFF_CTRL);
   assign wr_preset   = we && sel && (offset == OFF_PRESET);
   assign en          = ctrl[CTRL_EN];
   assign auto_reload = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);
   assign unused_addr_bits = ^addr[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         state    <= state_next;
         ctrl     <= ctrl_next;
         preset   <= preset_next;
         count    <= count_next;
         irq_flag <= irq_flag_next;
      end
   end

   // Expiry is detected while already sitting at zero, so COUNT never wraps.
   always_comb begin
      state_next  = state;
      count_next  = count;
      set_flag    = 1'b0;
      hw_clear_en = 1'b0;
      pulse_end   = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_next = LOAD;
         end
         LOAD: begin
            count_next = preset;
            state_next = CNT;
         end
         CNT: begin
            if (!en) begin
               state_next = IDLE;
            end else if (count == 32'd0) begin
               state_next = INT;
               set_flag   = 1'b1;
            end else begin
               count_next = count - 32'd1;
            end
         end
         INT: begin
            state_next = IDLE;
            if (auto_reload) pulse_end   = 1'b1;
            else             hw_clear_en = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // A CPU write to CTRL overrides the one-shot EN clear; a fresh expiry beats an acknowledge.
   always_comb begin
      ctrl_next = ctrl;
      if (wr_ctrl) begin
         ctrl_next = wdata[3:0];
      end else if (hw_clear_en) begin
         ctrl_next[CTRL_EN] = 1'b0;
      end

      preset_next = wr_preset ? wdata : preset;

      irq_flag_next = irq_flag;
      if (set_flag) begin
         irq_flag_next = 1'b1;
      end else if (wr_ctrl || wr_preset || pulse_end) begin
         irq_flag_next = 1'b0;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (sel) begin
         case (offset)
            OFF_CTRL:   rdata = {28'd0, ctrl};
            OFF_PRESET: rdata = preset;
            OFF_COUNT:  rdata = count;
            default:    rdata = 32'd0;
         endcase
      end
   end

   assign irq = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios followed by random bus
// traffic, all checked against a timestamp-based behavioural model of the timer.
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int compared   = 0;
   int mismatched = 0;

   // Model: a run starts on the edge where an idle timer sees EN; everything after
   // that is a fixed offset from the start edge and the preset latched one edge later.
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   logic        m_flag;
   bit          m_running;
   int          m_start;
   int          m_p;
   int          cyc = 0;

   timer_counter dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      if (a[31:4] != 28'h00007F0) return 32'd0;
      case (a[3:2])
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic modelEdge();
      bit in_win, wr_ctrl, wr_pre, set_flag, clr_en, pulse_end, en, auto_mode;
      int d;
      int k;
      k   = cyc;
      cyc = cyc + 1;
      if (reset) begin
         m_ctrl    = 4'd0;
         m_preset  = 32'd0;
         m_count   = 32'd0;
         m_flag    = 1'b0;
         m_running = 1'b0;
         return;
      end
      in_win    = (addr >= 32'h7F00) && (addr <= 32'h7F0F);
      wr_ctrl   = we && in_win && (addr[3:2] == 2'd0);
      wr_pre    = we && in_win && (addr[3:2] == 2'd1);
      en        = m_ctrl[0];
      auto_mode = (m_ctrl[2:1] == 2'b01);
      set_flag  = 1'b0;
      clr_en    = 1'b0;
      pulse_end = 1'b0;
      if (!m_running) begin
         if (en) begin
            m_running = 1'b1;
            m_start   = k;
         end
      end else begin
         d = k - m_start;
         if (d == 1) begin
            m_p     = int'(m_preset);
            m_count = m_preset;
         end else if (d >= 2 && d <= m_p + 2 && !en) begin
            m_running = 1'b0;
         end else if (d >= 2 && d <= m_p + 1) begin
            m_count = 32'(m_p - (d - 1));
         end else if (d == m_p + 2) begin
            set_flag = 1'b1;
         end else begin
            m_running = 1'b0;
            if (auto_mode) pulse_end = 1'b1;
            else           clr_en    = 1'b1;
         end
      end
      if (set_flag)                            m_flag = 1'b1;
      else if (wr_ctrl || wr_pre || pulse_end) m_flag = 1'b0;
      if (wr_ctrl)     m_ctrl    = wdata[3:0];
      else if (clr_en) m_ctrl[0] = 1'b0;
      if (wr_pre) m_preset = wdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One bus cycle: drive, compare against the model mid-cycle, clock, advance the model.
   task automatic applyStimulus(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
      reset = r;
      addr  = a;
      we    = w;
      wdata = d;
      @(negedge clk);
      if (!r) begin
         checkOutput("model_rdata", rdata, modelRead(a));
         checkOutput("model_irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
      end
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic idleRead(input logic [31:0] a, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, a, 1'b0, 32'd0);
   endtask

   initial begin
      logic [31:0] raddr, rdat;
      logic [31:0] addr_list [7];
      int          r;

      addr_list[0] = 32'h0000_7F00;
      addr_list[1] = 32'h0000_7F04;
      addr_list[2] = 32'h0000_7F08;
      addr_list[3] = 32'h0000_7F0C;
      addr_list[4] = 32'h0000_7F10;
      addr_list[5] = 32'h0000_7EFC;
      addr_list[6] = 32'h0010_7F04;

      reset = 1'b1;
      addr  = 32'h0000_7F00;
      we    = 1'b0;
      wdata = 32'd0;
      @(posedge clk);
      modelEdge();
      #1;

      $display("[TB] reset state");
      applyStimulus(1'b1, 32'h0000_7F00, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'h0000_7F00 + 32'(4 * i), 1'b0, 32'd0);
         checkOutput("reset_rdata", rdata, 32'd0);
         checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      end

      $display("[TB] one-shot expiry P=5");
      applyStimulus(1'b0, 32'h0000_7F04, 1'b1, 32'd5);
      applyStimulus(1'b0, 32'h0000_7F00, 1'b1, 32'h9);
      idleRead(32'h0000_7F08, 7);
      checkOutput("oneshot_irq_before", {31'd0, irq}, 32'd0);
      idleRead(32'h0000_7F08, 1);
      checkOutput("oneshot_irq_rise", {31'd0, irq}, 32'd1);
      idleRead(32'h0000_7F00, 1);
      checkOutput("oneshot_ctrl_en_clr", rdata, 32'h8);
      idleRead(32'h0000_7F00, 3);
      checkOutput("oneshot_irq_held", {31'd0, irq}, 32'd1);
      applyStimulus(1'b0, 32'h0000_7F04, 1'b1, 32'd5);
      checkOutput("oneshot_irq_ack", {31'd0, irq}, 32'd0);

      $display("[TB] auto-reload P=3");
      applyStimulus(1'b1, 32'h0000_7F00, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'h0000_7F04, 1'b1, 32'd3);
      applyStimulus(1'b0, 32'h0000_7F00, 1'b1, 32'hB);
      for (int i = 1; i <= 21; i++) begin
         idleRead(32'h0000_7F08, 1);
         checkOutput("auto_irq_pulse", {31'd0, irq}, {31'd0, (i >= 6) && ((i - 6) % 7 == 0)});
      end

      $display("[TB] stop mid-count P=10");
      applyStimulus(1'b1, 32'h0000_7F00, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'h0000_7F04, 1'b1, 32'd10);
      applyStimulus(1'b0, 32'h0000_7F00, 1'b1, 32'h1);
      idleRead(32'h0000_7F08, 4);
      applyStimulus(1'b0, 32'h0000_7F00, 1'b1, 32'h8);
      idleRead(32'h0000_7F08, 2);
      checkOutput("stop_count_frozen", rdata, 32'd7);
      idleRead(32'h0000_7F08, 3);
      checkOutput("stop_count_held", rdata, 32'd7);
      checkOutput("stop_no_irq", {31'd0, irq}, 32'd0);
      applyStimulus(1'b0, 32'h0000_7F08, 1'b1, 32'h55);
      checkOutput("count_write_ignored", rdata, 32'd7);
      applyStimulus(1'b0, 32'h0000_7F00, 1'b1, 32'h9);
      idleRead(32'h0000_7F08, 2);
      checkOutput("restart_reload", rdata, 32'd10);

      $display("[TB] masked expiry and decode");
      applyStimulus(1'b1, 32'h0000_7F00, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'h0000_7F04, 1'b1, 32'd2);
      applyStimulus(1'b0, 32'h0000_7F00, 1'b1, 32'h1);
      idleRead(32'h0000_7F00, 8);
      checkOutput("masked_irq", {31'd0, irq}, 32'd0);
      checkOutput("masked_ctrl", rdata, 32'd0);
      applyStimulus(1'b0, 32'h0000_7F00, 1'b1, 32'h8);
      checkOutput("ack_by_ctrl_write", {31'd0, irq}, 32'd0);
      applyStimulus(1'b0, 32'h0000_7F0C, 1'b1, 32'hFFFF_FFFF);
      checkOutput("reserved_read", rdata, 32'd0);
      applyStimulus(1'b0, 32'h0000_7F10, 1'b1, 32'h0000_000F);
      checkOutput("outside_read", rdata, 32'd0);
      idleRead(32'h0000_7F00, 1);
      checkOutput("outside_write_ignored", rdata, 32'h8);

      $display("[TB] reset mid-count");
      applyStimulus(1'b1, 32'h0000_7F00, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'h0000_7F04, 1'b1, 32'd8);
      applyStimulus(1'b0, 32'h0000_7F00, 1'b1, 32'h9);
      idleRead(32'h0000_7F08, 6);
      checkOutput("pre_reset_count", rdata, 32'd4);
      applyStimulus(1'b1, 32'h0000_7F08, 1'b0, 32'd0);
      checkOutput("post_reset_count", rdata, 32'd0);
      checkOutput("post_reset_irq", {31'd0, irq}, 32'd0);
      idleRead(32'h0000_7F00, 1);
      checkOutput("post_reset_ctrl", rdata, 32'd0);
      idleRead(32'h0000_7F04, 1);
      checkOutput("post_reset_preset", rdata, 32'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 2000; i++) begin
         r     = int'($urandom_range(0, 99));
         raddr = addr_list[$urandom_range(0, 6)];
         rdat  = $urandom();
         if (r < 2) begin
            applyStimulus(1'b1, raddr, 1'b0, rdat);
         end else if (r < 10) begin
            rdat[0] = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b0, 32'h0000_7F00, 1'b1, rdat);
         end else if (r < 16) begin
            applyStimulus(1'b0, 32'h0000_7F04, 1'b1, 32'($urandom_range(0, 12)));
         end else if (r < 20) begin
            applyStimulus(1'b0, raddr, 1'b1, rdat);
         end else begin
            applyStimulus(1'b0, raddr, 1'b0, rdat);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
